// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS time-of-day counter in packed BCD with RUN/SET editing and midnight strobe.
// Optional alarm comparator and sticky flag when TK_ALARM_EN is defined.
module time_keeper (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
`ifdef TK_ALARM_EN
    input  logic [5:0] alarm_hr,
    input  logic [6:0] alarm_min,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       day_tick
);

    // state | meaning
    // RUN   | time advances on tick_1s, inc_* ignored
    // SET   | seconds frozen, inc_min / inc_hour edit the time
    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

    state_t     state, state_nx;
    logic [3:0] sec_ones_nx, min_ones_nx, hr_ones_nx;
    logic [2:0] sec_tens_nx, min_tens_nx;
    logic [1:0] hr_tens_nx;
    logic       day_tick_nx;
    logic       alarm_hit;

    // {tens, ones} +1 mod 60
    function automatic logic [6:0] min_inc(input logic [2:0] t, input logic [3:0] o);
        if (o != 4'd9)      return {t, o + 4'd1};
        else if (t != 3'd5) return {t + 3'd1, 4'd0};
        else                return 7'd0;
    endfunction

    // {tens, ones} +1 mod 24
    function automatic logic [5:0] hr_inc(input logic [1:0] t, input logic [3:0] o);
        if (t == 2'd2 && o == 4'd3) return 6'd0;
        else if (o == 4'd9)         return {t + 2'd1, 4'd0};
        else                        return {t, o + 4'd1};
    endfunction

    always_comb begin
        state_nx    = state;
        sec_ones_nx = sec_ones;
        sec_tens_nx = sec_tens;
        min_ones_nx = min_ones;
        min_tens_nx = min_tens;
        hr_ones_nx  = hr_ones;
        hr_tens_nx  = hr_tens;
        day_tick_nx = 1'b0;
        alarm_hit   = 1'b0;
        // set_mode is decoded ahead of the state so a tick on the entry edge is dropped
        if (set_mode) begin
            state_nx = SET;
            if (inc_min)
                {min_tens_nx, min_ones_nx} = min_inc(min_tens, min_ones);
            if (inc_hour)
                {hr_tens_nx, hr_ones_nx} = hr_inc(hr_tens, hr_ones);
        end else if (state == SET) begin
            state_nx    = RUN;
            sec_ones_nx = 4'd0;
            sec_tens_nx = 3'd0;
        end else if (tick_1s) begin
            if (sec_ones != 4'd9) begin
                sec_ones_nx = sec_ones + 4'd1;
            end else if (sec_tens != 3'd5) begin
                sec_ones_nx = 4'd0;
                sec_tens_nx = sec_tens + 3'd1;
            end else begin
                sec_ones_nx = 4'd0;
                sec_tens_nx = 3'd0;
                {min_tens_nx, min_ones_nx} = min_inc(min_tens, min_ones);
                if (min_tens == 3'd5 && min_ones == 4'd9) begin
                    {hr_tens_nx, hr_ones_nx} = hr_inc(hr_tens, hr_ones);
                    day_tick_nx = (hr_tens == 2'd2 && hr_ones == 4'd3);
                end
`ifdef TK_ALARM_EN
                alarm_hit = ({hr_tens_nx, hr_ones_nx} == alarm_hr) &&
                            ({min_tens_nx, min_ones_nx} == alarm_min);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            sec_ones <= 4'd0;
            sec_tens <= 3'd0;
            min_ones <= 4'd0;
            min_tens <= 3'd0;
            hr_ones  <= 4'd0;
            hr_tens  <= 2'd0;
            day_tick <= 1'b0;
        end else begin
            state    <= state_nx;
            sec_ones <= sec_ones_nx;
            sec_tens <= sec_tens_nx;
            min_ones <= min_ones_nx;
            min_tens <= min_tens_nx;
            hr_ones  <= hr_ones_nx;
            hr_tens  <= hr_tens_nx;
            day_tick <= day_tick_nx;
        end
    end

`ifdef TK_ALARM_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            alarm <= 1'b0;
        else if (alarm_arm && alarm_hit)
            alarm <= 1'b1;
        else if (alarm_ack || !alarm_arm)
            alarm <= 1'b0;
    end
`else
    logic unused_alarm;
    assign unused_alarm = alarm_hit;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: reset, full-day rollover, carry chain, SET editing, priority, reset-in-SET.
// Alarm checks are compiled in when TK_ALARM_EN is defined.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1s = 1'b0, set_mode = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
    logic [3:0] sec_ones, min_ones, hr_ones;
    logic [2:0] sec_tens, min_tens;
    logic [1:0] hr_tens;
    logic       day_tick;
`ifdef TK_ALARM_EN
    logic [5:0] alarm_hr = 6'h00;
    logic [6:0] alarm_min = 7'h00;
    logic       alarm_arm = 1'b0, alarm_ack = 1'b0;
    logic       alarm;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    time_keeper dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hour(inc_hour),
`ifdef TK_ALARM_EN
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .alarm(alarm),
`endif
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    logic [19:0] now;
    assign now = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [19:0] hms(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit legal();
        return sec_ones <= 4'd9 && sec_tens <= 3'd5 && min_ones <= 4'd9 && min_tens <= 3'd5 &&
               hr_ones <= 4'd9 && hr_tens <= 2'd2 && !(hr_tens == 2'd2 && hr_ones > 4'd3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // From any state: enter SET, add h hours and m minutes, return to RUN, tick s seconds.
    task automatic advance(input int h, input int m, input int s);
        set_mode = 1'b1; step();
        inc_hour = 1'b1; steps(h); inc_hour = 1'b0;
        inc_min  = 1'b1; steps(m); inc_min  = 1'b0;
        set_mode = 1'b0; step();
        tick_1s  = 1'b1; steps(s); tick_1s  = 1'b0;
    endtask

    int dt_count, dt_last, bad_bcd;

    initial begin
        #1;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("reset_time", 32'(now), 32'(hms(0, 0, 0)));
        check("reset_day_tick", 32'(day_tick), 32'd0);

        // full day of back-to-back ticks
        dt_count = 0; dt_last = -1; bad_bcd = 0;
        tick_1s = 1'b1;
        for (int i = 0; i < 86400; i++) begin
            step();
            if (day_tick) begin dt_count++; dt_last = i; end
            if (!legal()) bad_bcd++;
            if (i == 3660) check("mid_day_01_01_01", 32'(now), 32'(hms(1, 1, 1)));
            if (i == 86398) check("pre_roll_23_59_59", 32'(now), 32'(hms(23, 59, 59)));
        end
        tick_1s = 1'b0;
        check("rollover_time", 32'(now), 32'(hms(0, 0, 0)));
        check("rollover_dt_count", 32'(dt_count), 32'd1);
        check("rollover_dt_last", 32'(dt_last), 32'd86399);
        check("rollover_bcd_legal", 32'(bad_bcd), 32'd0);
        step();
        check("day_tick_one_cycle", 32'(day_tick), 32'd0);

        // carry chain from 12:59:00
        set_mode = 1'b1; step();
        inc_hour = 1'b1; steps(12); inc_hour = 1'b0;
        inc_min  = 1'b1; steps(59); inc_min  = 1'b0;
        check("set_12_59", 32'(now), 32'(hms(12, 59, 0)));
        set_mode = 1'b0; step();
        bad_bcd = 0;
        tick_1s = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!legal()) bad_bcd++;
            if (i == 58) check("carry_12_59_59", 32'(now), 32'(hms(12, 59, 59)));
        end
        tick_1s = 1'b0;
        check("carry_13_00_00", 32'(now), 32'(hms(13, 0, 0)));
        check("carry_bcd_legal", 32'(bad_bcd), 32'd0);

        // tick on the same edge set_mode rises is dropped; ticks in SET hold seconds
        tick_1s = 1'b1; steps(7);
        set_mode = 1'b1; step();
        check("tick_on_set_entry", 32'(now), 32'(hms(13, 0, 7)));
        steps(5); tick_1s = 1'b0;
        check("ticks_in_set", 32'(now), 32'(hms(13, 0, 7)));
        inc_hour = 1'b1; steps(10); inc_hour = 1'b0;
        inc_min  = 1'b1; steps(59); inc_min  = 1'b0;
        check("set_23_59", 32'(now), 32'(hms(23, 59, 7)));
        inc_min = 1'b1; inc_hour = 1'b1; step(); inc_min = 1'b0; inc_hour = 1'b0;
        check("both_inc_wrap", 32'(now), 32'(hms(0, 0, 7)));
        check("no_day_tick_in_set", 32'(day_tick), 32'd0);
        set_mode = 1'b0; step();
        check("secs_clear_on_run", 32'(now), 32'(hms(0, 0, 0)));

        // inc pulses ignored in RUN
        advance(5, 10, 7);
        check("goto_05_10_07", 32'(now), 32'(hms(5, 10, 7)));
        inc_min = 1'b1; step(); inc_min = 1'b0;
        check("inc_min_in_run", 32'(now), 32'(hms(5, 10, 7)));
        inc_hour = 1'b1; step(); inc_hour = 1'b0;
        check("inc_hour_in_run", 32'(now), 32'(hms(5, 10, 7)));

        // reset while in SET at 17:42:33
        tick_1s = 1'b1; steps(26); tick_1s = 1'b0;
        set_mode = 1'b1; step();
        inc_hour = 1'b1; steps(12); inc_hour = 1'b0;
        inc_min  = 1'b1; steps(32); inc_min  = 1'b0;
        check("set_17_42_33", 32'(now), 32'(hms(17, 42, 33)));
        rst_n = 1'b0; step(); rst_n = 1'b1; set_mode = 1'b0;
        check("reset_in_set_time", 32'(now), 32'(hms(0, 0, 0)));
        check("reset_in_set_dt", 32'(day_tick), 32'd0);
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        check("reset_state_is_run", 32'(now), 32'(hms(0, 0, 1)));

`ifdef TK_ALARM_EN
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("alarm_reset", 32'(alarm), 32'd0);
        alarm_hr = 6'h06; alarm_min = 7'h30; alarm_arm = 1'b1;
        advance(6, 29, 59);
        check("alarm_pre", 32'(alarm), 32'd0);
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        check("alarm_time", 32'(now), 32'(hms(6, 30, 0)));
        check("alarm_set", 32'(alarm), 32'd1);
        step();
        check("alarm_sticky", 32'(alarm), 32'd1);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        check("alarm_ack", 32'(alarm), 32'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        alarm_arm = 1'b0;
        advance(6, 29, 59);
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        check("alarm_unarmed", 32'(alarm), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter that consumes the one-cycle `tick_1s` strobe from the clock divider and maintains a 24-hour HH:MM:SS time in packed BCD digits for the display path. It provides a RUN/SET mode for manual time entry via single-cycle increment pulses and flags the midnight rollover. It sits between the divider and the seven-segment display multiplexer.

## Interface
- No parameters; the 24-hour format and BCD encoding are fixed.
- `clk`  in  1  system clock, the same clock that drives the divider.
- `rst_n`  in  1  synchronous, active-low reset.
- `tick_1s`  in  1  one-cycle strobe, once per second, from the divider.
- `set_mode`  in  1  level; 1 = SET state, 0 = RUN state.
- `inc_min`  in  1  one-cycle pulse (already debounced); minute +1, honoured in SET only.
- `inc_hour`  in  1  one-cycle pulse (already debounced); hour +1, honoured in SET only.
- `sec_ones`  out  4  BCD 0–9.
- `sec_tens`  out  3  BCD 0–5.
- `min_ones`  out  4  BCD 0–9.
- `min_tens`  out  3  BCD 0–5.
- `hr_ones`  out  4  BCD 0–9, limited to 0–3 when `hr_tens` = 2.
- `hr_tens`  out  2  BCD 0–2.
- `day_tick`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover.
- `alarm_hr`  in  6  {tens[1:0], ones[3:0]} BCD. Present only with `TK_ALARM_EN`.
- `alarm_min`  in  7  {tens[2:0], ones[3:0]} BCD. Present only with `TK_ALARM_EN`.
- `alarm_arm`  in  1  level; enables the alarm. Present only with `TK_ALARM_EN`.
- `alarm_ack`  in  1  pulse; clears `alarm`. Present only with `TK_ALARM_EN`.
- `alarm`  out  1  sticky alarm flag. Present only with `TK_ALARM_EN`.

## Operation
- State machine has two states, RUN and SET, held in one state register.
  - RUN → SET when `set_mode` = 1.
  - SET → RUN when `set_mode` = 0.
- On every SET → RUN transition, `sec_*` is cleared to 00.
- RUN, `tick_1s` = 1: seconds increment with a BCD ripple.
  - `sec_ones` 9 → 0 carries into `sec_tens`; `sec_tens` 5 → 0 carries into the minutes.
  - Minutes behave the same way and carry into the hours.
  - Hours go 23 → 00, and `day_tick` is asserted on that transition.
- RUN: `inc_min` and `inc_hour` are ignored.
- SET: `tick_1s` is ignored; the seconds hold their value.
  - `inc_min`: minutes go +1 mod 60, with no carry into the hours.
  - `inc_hour`: hours go +1 mod 24.
  - `inc_min` and `inc_hour` in the same cycle: both increments apply independently.
  - `day_tick` is never asserted in SET.
- `tick_1s` in the same cycle that `set_mode` rises: the tick is discarded, because SET decoding takes priority.
- No digit ever holds an illegal BCD value. Every comparison is an equality on digit boundaries, with no binary-to-BCD conversion.

## Timing
- Reset (`rst_n` = 0 at a rising `clk` edge):
  - All digits go to 0, giving 00:00:00.
  - `day_tick` = 0, state = RUN, `alarm` = 0.
- Reset dominates every other input. Reset asserted mid-ripple or in SET returns the block to RUN at 00:00:00 on that edge.
- Latency: every output is registered. A `tick_1s` or `inc_*` sampled at edge N is visible after edge N.
- `day_tick` is high for exactly the one cycle after the edge that wraps the time to 00:00:00.
- `tick_1s` arriving on consecutive cycles (divider test mode) must increment once per cycle. The block has no rate assumption.

## Configuration
- `TK_ALARM_EN` defined:
  - The alarm ports exist.
  - `alarm` sets on the RUN-state edge where a tick makes seconds reach 00 and HH:MM equals `alarm_hr:alarm_min`, provided `alarm_arm` = 1.
  - `alarm` stays set until `alarm_ack`, `alarm_arm` = 0, or reset.
  - If a set event and `alarm_ack` coincide, the set wins.
  - SET-state edits never trigger the alarm.
- `TK_ALARM_EN` undefined: the alarm ports and alarm logic are absent, and the time behaviour is identical.

## Test plan
- Rollover: reset, then 86400 `tick_1s` pulses → time reads 00:00:00; `day_tick` is seen exactly once, on the final tick.
- Carry chain: set 12:59 in SET, return to RUN, apply 60 ticks → 13:00:00 after the 60th tick, with no intermediate illegal BCD digit.
- SET editing: set 23:59, pulse `inc_min` and `inc_hour` together → 00:00. Seconds read 00 on re-entering RUN. Ticks in SET leave seconds unchanged.
- Priority: `tick_1s` in the same cycle `set_mode` rises → no increment. `inc_min` in RUN at 05:10:07 → no change.
- Reset mid-operation: drive `rst_n` = 0 for one edge at 17:42:33 in SET → next cycle reads 00:00:00 in RUN with `day_tick` = 0.
- Alarm (`TK_ALARM_EN`): `alarm` = 06:30, armed, time 06:29:59, one tick → `alarm` = 1. `alarm_ack` → `alarm` = 0. Repeat with `alarm_arm` = 0 → `alarm` stays 0.
